// File: rtl/alu_word_sequencer.sv
// Word-wide ALU operations sequenced one nibble per clock over a shared 4-bit alu.
// The carry chains from nibble to nibble through the registered carry_in field of alu_args.

package alu_word_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    typedef enum logic [2:0] {
        CMD_ADD   = 3'd0,
        CMD_AND   = 3'd1,
        CMD_OR    = 3'd2,
        CMD_XOR   = 3'd3,
        CMD_XNOR  = 3'd4,
        CMD_RSHFT = 3'd5
    } alu_cmd_e;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        alu_cmd_e   cmd;
        logic       b_inv;
        logic       carry_disable;
        logic       carry_in;
    } alu_args_t;

    typedef struct packed {
        logic [3:0] res;
        logic       carry_out;
    } alu_ret_t;

    localparam int unsigned ALU_ARGS_W = $bits(alu_args_t);
    localparam int unsigned ALU_RET_W  = $bits(alu_ret_t);

endpackage

module alu_word_sequencer
    import alu_word_sequencer_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [4*NIBBLES-1:0]  a,
    input  logic [4*NIBBLES-1:0]  b,
    output logic                  ready,
    output logic                  done,
    output logic [4*NIBBLES-1:0]  result,
    output logic                  carry_out,
    output logic                  zero,
    output logic [ALU_ARGS_W-1:0] alu_args,
    input  logic [ALU_RET_W-1:0]  alu_ret
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     shadow;
    logic [W-1:0]     shadow_next;
    alu_args_t        args_q;
    alu_ret_t         ret;

    assign ret      = alu_ret;
    assign alu_args = args_q;

    // ALU control for nibble k of a word operation, given the carry into that nibble.
    function automatic alu_args_t nibble_args(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input int unsigned k,
                                              input logic cin);
        alu_args_t r;
        logic [W:0] above;
        r     = '0;
        above = {1'b0, x} >> (4 * k + 4);
        r.d1  = 4'(x >> (4 * k));
        r.d2  = 4'(y >> (4 * k));
        case (o)
            OP_ADD: begin
                r.cmd      = CMD_ADD;
                r.carry_in = cin;
            end
            OP_SUB, OP_CMP: begin
                r.cmd      = CMD_ADD;
                r.b_inv    = 1'b1;
                r.carry_in = cin;
            end
            OP_AND:  begin r.cmd = CMD_AND;  r.carry_disable = 1'b1; end
            OP_OR:   begin r.cmd = CMD_OR;   r.carry_disable = 1'b1; end
            OP_XOR:  begin r.cmd = CMD_XOR;  r.carry_disable = 1'b1; end
            OP_XNOR: begin r.cmd = CMD_XNOR; r.carry_disable = 1'b1; end
            default: begin
                // SHR: the bit shifted in is the LSB of the next nibble up (0 above the word)
                r.cmd      = CMD_RSHFT;
                r.d1       = 4'h0;
                r.d2       = 4'(x >> (4 * k));
                r.carry_in = above[0];
            end
        endcase
        return r;
    endfunction

    always_comb begin
        shadow_next = (shadow & ~(W'(4'hF) << (4 * 32'(idx)))) | (W'(ret.res) << (4 * 32'(idx)));
    end

    // Outputs are committed on the last RUN edge so DONE doubles as an accept slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx       <= '0;
            shadow    <= '0;
            args_q    <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        idx    <= '0;
                        args_q <= nibble_args(op, a, b, 0, (op == OP_SUB) || (op == OP_CMP));
                        ready  <= 1'b0;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    shadow <= shadow_next;
                    if (idx == LAST) begin
                        args_q <= '0;
                        if (op_q != OP_CMP) begin
                            result <= shadow_next;
                        end
                        zero <= (shadow_next == '0);
                        case (op_q)
                            OP_ADD, OP_SUB, OP_CMP: carry_out <= ret.carry_out;
                            OP_SHR:                 carry_out <= a_q[0];
                            default:                carry_out <= 1'b0;
                        endcase
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        args_q <= nibble_args(op_q, a_q, b_q, 32'(idx) + 32'd1, ret.carry_out);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Scoreboard bench for alu_word_sequencer: word-level reference model, behavioural 4-bit alu,
// directed corner cases plus random jobs, mid-job reset and ignored-start checks.
module tb_alu_word_sequencer;
    import alu_word_sequencer_pkg::*;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [2:0]            op;
    logic [W-1:0]          a;
    logic [W-1:0]          b;
    logic                  ready;
    logic                  done;
    logic [W-1:0]          result;
    logic                  carry_out;
    logic                  zero;
    logic [ALU_ARGS_W-1:0] alu_args;
    logic [ALU_RET_W-1:0]  alu_ret;

    alu_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .alu_args(alu_args), .alu_ret(alu_ret)
    );

    // Behavioural 4-bit alu
    alu_args_t args_s;
    alu_ret_t  ret_s;
    logic [4:0] sum;
    assign args_s  = alu_args;
    assign alu_ret = ret_s;
    always_comb begin
        ret_s = '0;
        sum   = '0;
        case (args_s.cmd)
            CMD_ADD: begin
                sum = {1'b0, args_s.d1} + {1'b0, (args_s.b_inv ? ~args_s.d2 : args_s.d2)}
                      + {4'b0, (args_s.carry_disable ? 1'b0 : args_s.carry_in)};
                ret_s.res       = sum[3:0];
                ret_s.carry_out = sum[4];
            end
            CMD_AND:  ret_s.res = args_s.d1 & args_s.d2;
            CMD_OR:   ret_s.res = args_s.d1 | args_s.d2;
            CMD_XOR:  ret_s.res = args_s.d1 ^ args_s.d2;
            CMD_XNOR: ret_s.res = ~(args_s.d1 ^ args_s.d2);
            CMD_RSHFT: begin
                ret_s.res       = {args_s.carry_in, args_s.d2[3:1]};
                ret_s.carry_out = args_s.d2[0];
            end
            default: ret_s = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           tests  = 0;
    int           failed = 0;
    logic [W-1:0] model_result = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [W-1:0] prev);
        exp_t e;
        logic [W:0] s;
        e.result = prev;
        e.carry  = 1'b0;
        e.cyc    = 0;
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; e.result = s[W-1:0]; e.carry = s[W]; end
            3'd1: begin e.result = x - y; e.carry = (x >= y); end
            3'd2: e.result = x & y;
            3'd3: e.result = x | y;
            3'd4: e.result = x ^ y;
            3'd5: e.result = ~(x ^ y);
            3'd6: begin e.result = x >> 1; e.carry = x[0]; end
            default: e.carry = (x >= y);
        endcase
        e.zero = (o == 3'd7) ? (x == y) : (e.result == '0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding job
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.result));
                check("carry_out", 32'(carry_out), 32'(e.carry));
                check("zero", 32'(zero), 32'(e.zero));
                check("latency", 32'(cyc - e.cyc), 32'(NIB + 1));
                check("ready_in_done", 32'(ready), 32'd1);
            end
        end
    end

    // Called and returns at a negedge; the job is accepted on the following posedge.
    task automatic run_job(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(ready), 32'd1);
        e     = model(o, x, y, model_result);
        e.cyc = cyc;
        if (o != 3'd7) model_result = e.result;
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 3'($urandom);
        check("ready_low_after_accept", 32'(ready), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return '0;
        if (r == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_alu_args", 32'(alu_args), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(3'd0, 16'hFFFF, 16'h0001);
        run_job(3'd1, 16'h1234, 16'h1235);
        run_job(3'd1, 16'h1235, 16'h1234);
        run_job(3'd0, 16'h0040, 16'h0002);
        run_job(3'd7, 16'hA5A5, 16'hA5A5);
        run_job(3'd7, 16'h8000, 16'h7FFF);
        run_job(3'd6, 16'h8421, 16'h0000);
        run_job(3'd5, 16'h0F0F, 16'h00FF);
        check("alu_args_idle_gap_free", 32'(ready), 32'd0);

        for (int n = 0; n < 150; n++) begin
            run_job(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        // start while busy is ignored: one done for the accepted ADD only
        run_job(3'd0, 16'h1111, 16'h2222);
        @(negedge clk);
        check("busy_ready", 32'(ready), 32'd0);
        start = 1'b1;
        op    = 3'd1;
        a     = 16'h0F0F;
        b     = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        run_job(3'd4, 16'hFF00, 16'h0FF0);

        // reset in the 3rd RUN cycle aborts the job
        run_job(3'd0, 16'h7777, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_result = '0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_alu_args", 32'(alu_args), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(3'd0, 16'h0101, 16'h0202);
        run_job(3'd7, 16'h0001, 16'h0002);

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (8) @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_alu_args", 32'(alu_args), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-cycle controller that performs NIBBLES×4-bit word operations on the shared 4-bit `alu` datapath, one nibble per clock, carry chained through a register. It sits between an instruction/execute stage and a single `alu` instance: it accepts a word operation, drives `AluArgs` nibble by nibble, collects `AluRet`, and returns the word result with flags.

## Interface

- `NIBBLES`, default 4: operand width in nibbles (word width W = 4×NIBBLES); legal range 1..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only when `ready`=1.
- `op`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 SHR, 7 CMP.
- `a`, `b`  in  W each  operands; sampled with `start`.
- `ready`  out  1  idle, can accept `start`.
- `done`  out  1  one-cycle pulse: `result`/flags updated.
- `result`  out  W  word result.
- `carry_out`  out  1  final carry flag.
- `zero`  out  1  word result == 0.
- `alu_args`  out  AluArgs  to the `alu` instance: `d1`, `d2`, `ctrl`.
- `alu_ret`  in  AluRet  from the `alu` instance: `res`, `carry_out`.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`=1, latch `a`, `b`, `op`; clear nibble index `i`; load carry register (1 for SUB/CMP, else 0); go to RUN.
- RUN: `ready`=0; nibble `i` (LSB nibble first) is driven to the ALU.
  - `d1`=a[4i+3:4i], `d2`=b[4i+3:4i]. SHR only: `d1`=0, `d2`=a nibble.
  - ADD: cmd ADD, `b_inv`=0, `carry_disable`=0, `carry_in`=carry reg.
  - SUB/CMP: cmd ADD, `b_inv`=1, `carry_disable`=0, `carry_in`=carry reg (1 at i=0).
  - AND/OR/XOR/XNOR: matching cmd, `b_inv`=0, `carry_disable`=1, `carry_in`=0.
  - SHR: cmd RSHFT, `b_inv`=0, `carry_disable`=0, `carry_in`=a[4i+4] for i<NIBBLES-1, 0 for the top nibble (logical shift).
  - Each edge: write `alu_ret.res` into nibble `i` of a shadow result; store `alu_ret.carry_out` in the carry register; increment `i`. After nibble NIBBLES-1, go to DONE.
- DONE: commit outputs and go to IDLE.
  - `result`: shadow result; CMP leaves `result` unchanged.
  - `carry_out`: ADD = unsigned overflow; SUB/CMP = 1 iff a ≥ b (unsigned); SHR = a[0]; logic ops = 0.
  - `zero`: shadow result == 0 for every op, including CMP (a==b).
  - CMP decode: a==b ⇔ `zero`; a>b ⇔ `carry_out` & ~`zero`.
- Outputs hold their values until the next DONE.
- Outside RUN, `alu_args` is all-zero.
- Width rules: intermediate results are truncated to W bits. Carry-out above bit W is only visible through `carry_out`.

## Timing

- Reset values, applied immediately when `rst_n` falls: state IDLE; `ready`=1; `done`=0; `result`=0; `carry_out`=0; `zero`=1; `alu_args`=0; internal registers 0.
- `start` sampled at edge E0 → RUN covers edges E1..E_NIBBLES → `done`=1 in the cycle after E_(NIBBLES+1)-1. The full job takes NIBBLES+1 cycles; `done` is high for exactly one cycle, coincident with the new `result`.
- `ready` falls the cycle after `start` is accepted. It rises again in the same cycle `done` pulses, so back-to-back `start` is legal: one job every NIBBLES+1 cycles.
- `start` while `ready`=0 is ignored, not queued. Operand changes after acceptance have no effect.
- `alu` is purely combinational: `alu_ret` must settle within the same cycle as `alu_args`.
- Reset mid-RUN aborts the job: no `done` pulse, and outputs take their reset values.
- NIBBLES=1: one RUN cycle, latency 2.

## Test plan

- NIBBLES=4, ADD a=0xFFFF b=0x0001 → `result`=0x0000, `carry_out`=1, `zero`=1; `done` 5 cycles after `start`.
- SUB a=0x1234 b=0x1235 → `result`=0xFFFF, `carry_out`=0, `zero`=0. SUB a=0x1235 b=0x1234 → `result`=0x0001, `carry_out`=1.
- CMP a=b=0xA5A5 after a prior ADD result 0x0042 → `result` stays 0x0042, `zero`=1, `carry_out`=1. CMP a=0x8000 b=0x7FFF → `zero`=0, `carry_out`=1.
- SHR a=0x8421 → `result`=0x4210, `carry_out`=1. XNOR a=0x0F0F b=0x00FF → `result`=0xF00F, `carry_out`=0.
- `start` pulsed again 2 cycles into an ADD with different operands → ignored; first result returned once, with a single `done` pulse. A back-to-back `start` in the `done` cycle is accepted.
- `rst_n` low in the 3rd RUN cycle → immediately `ready`=1, `result`=0, `zero`=1; no `done` pulse. A new ADD after release completes normally.
